// File: rtl/reg_wb_queue.sv
// Write-back queue in front of the single-write-port register file: merges
// MEM and ALU results in order, drains one per cycle, and offers a pending-write lookup.
module reg_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_valid,
    input  logic [4:0]    mem_wn,
    input  logic [DW-1:0] mem_wd,
    input  logic          alu_valid,
    input  logic [4:0]    alu_wn,
    input  logic [DW-1:0] alu_wd,
    output logic          ready,
    output logic          RegWrite,
    output logic [4:0]    WN,
    output logic [DW-1:0] WD,
    input  logic [4:0]    q_rn,
    output logic          q_hit,
    output logic [DW-1:0] q_data,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam int unsigned CW        = AW + 1;
    localparam logic [AW:0] READY_MAX = CW'(DEPTH - 2);

    logic [4:0]    wn_q [DEPTH];
    logic [DW-1:0] wd_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] alu_slot;
    logic [AW:0]   push_n;
    logic          mem_req;
    logic          alu_req;
    logic          mem_acc;
    logic          alu_acc;
    logic          pop;

    // Space for a full pair is guaranteed whenever ready is high, so no per-source check.
    assign ready    = (count <= READY_MAX);
    assign mem_req  = mem_valid && (mem_wn != 5'd0);
    assign alu_req  = alu_valid && (alu_wn != 5'd0);
    assign mem_acc  = mem_req && ready;
    assign alu_acc  = alu_req && ready;
    assign pop      = (count != '0);
    assign push_n   = CW'(mem_acc) + CW'(alu_acc);
    assign alu_slot = wr_ptr + AW'(mem_acc);

    // Control state, drain into the output register, sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            RegWrite <= 1'b0;
            WN       <= '0;
            WD       <= '0;
            overflow <= 1'b0;
        end else begin
            count  <= count + push_n - CW'(pop);
            wr_ptr <= wr_ptr + AW'(push_n);
            if ((mem_req || alu_req) && !ready) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                RegWrite <= 1'b1;
                WN       <= wn_q[rd_ptr];
                WD       <= wd_q[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end else begin
                RegWrite <= 1'b0;
            end
        end
    end

    // Entry storage; mem is the older instruction so it takes the lower slot.
    always_ff @(posedge clk) begin
        if (mem_acc) begin
            wn_q[wr_ptr] <= mem_wn;
            wd_q[wr_ptr] <= mem_wd;
        end
        if (alu_acc) begin
            wn_q[alu_slot] <= alu_wn;
            wd_q[alu_slot] <= alu_wd;
        end
    end

    // Youngest pending write wins: output register first, then FIFO oldest to newest.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        if (q_rn != 5'd0) begin
            if (RegWrite && (WN == q_rn)) begin
                q_hit  = 1'b1;
                q_data = WD;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count) && (wn_q[rd_ptr + AW'(i)] == q_rn)) begin
                    q_hit  = 1'b1;
                    q_data = wd_q[rd_ptr + AW'(i)];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed self-checking bench for reg_wb_queue: a per-cycle vector table plus
// hand-written steady-state and mid-operation reset sequences.
module tb_reg_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned NVEC  = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_valid;
    logic [4:0]    mem_wn;
    logic [DW-1:0] mem_wd;
    logic          alu_valid;
    logic [4:0]    alu_wn;
    logic [DW-1:0] alu_wd;
    logic          ready;
    logic          RegWrite;
    logic [4:0]    WN;
    logic [DW-1:0] WD;
    logic [4:0]    q_rn;
    logic          q_hit;
    logic [DW-1:0] q_data;
    logic [AW:0]   count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    reg_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_wn(mem_wn), .mem_wd(mem_wd),
        .alu_valid(alu_valid), .alu_wn(alu_wn), .alu_wd(alu_wd),
        .ready(ready), .RegWrite(RegWrite), .WN(WN), .WD(WD),
        .q_rn(q_rn), .q_hit(q_hit), .q_data(q_data),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mv;
        logic [4:0]  mwn;
        logic [31:0] mwd;
        logic        av;
        logic [4:0]  awn;
        logic [31:0] awd;
        logic [4:0]  qrn;
        logic        e_ready;
        logic        e_rw;
        logic [4:0]  e_wn;
        logic [31:0] e_wd;
        logic        e_hit;
        logic [31:0] e_qd;
        logic [2:0]  e_count;
        logic        e_ovf;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] mwn, input logic [31:0] mwd,
                         input logic av, input logic [4:0] awn, input logic [31:0] awd,
                         input logic [4:0] qrn);
        mem_valid = mv;  mem_wn = mwn;  mem_wd = mwd;
        alu_valid = av;  alu_wn = awn;  alu_wd = awd;
        q_rn      = qrn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // idx: mem v/wn/wd, alu v/wn/wd, q_rn | ready, RegWrite, WN, WD, q_hit, q_data, count, overflow
        // single mem write through the queue
        vecs[0]  = '{1, 5, 32'h11,  0, 0, 0,      5, 1, 0, 0, 32'h0,   1, 32'h11,  1, 0};
        vecs[1]  = '{0, 0, 0,       0, 0, 0,      5, 1, 1, 5, 32'h11,  1, 32'h11,  0, 0};
        vecs[2]  = '{0, 0, 0,       0, 0, 0,      5, 1, 0, 5, 32'h11,  0, 32'h0,   0, 0};
        // same-cycle pair to r3: mem first, alu is youngest
        vecs[3]  = '{1, 3, 32'hA,   1, 3, 32'hB,  3, 1, 0, 5, 32'h11,  1, 32'hB,   2, 0};
        vecs[4]  = '{0, 0, 0,       0, 0, 0,      3, 1, 1, 3, 32'hA,   1, 32'hB,   1, 0};
        vecs[5]  = '{0, 0, 0,       0, 0, 0,      3, 1, 1, 3, 32'hB,   1, 32'hB,   0, 0};
        vecs[6]  = '{0, 0, 0,       0, 0, 0,      3, 1, 0, 3, 32'hB,   0, 32'h0,   0, 0};
        // writes to r0 are filtered and r0 lookup never hits
        vecs[7]  = '{0, 0, 0,       1, 0, 32'hFF, 0, 1, 0, 3, 32'hB,   0, 32'h0,   0, 0};
        vecs[8]  = '{0, 0, 0,       0, 0, 0,      0, 1, 0, 3, 32'hB,   0, 32'h0,   0, 0};
        // fill with pairs: third pair is dropped, pointers wrap past DEPTH
        vecs[9]  = '{1, 1, 32'h101, 1, 2, 32'h102, 2, 1, 0, 3, 32'hB,   1, 32'h102, 2, 0};
        vecs[10] = '{1, 4, 32'h104, 1, 6, 32'h106, 1, 0, 1, 1, 32'h101, 1, 32'h101, 3, 0};
        vecs[11] = '{1, 7, 32'h107, 1, 8, 32'h108, 7, 1, 1, 2, 32'h102, 0, 32'h0,   2, 1};
        vecs[12] = '{0, 0, 0,       0, 0, 0,      6, 1, 1, 4, 32'h104, 1, 32'h106, 1, 1};
        vecs[13] = '{0, 0, 0,       0, 0, 0,      6, 1, 1, 6, 32'h106, 1, 32'h106, 0, 1};
        vecs[14] = '{0, 0, 0,       0, 0, 0,      8, 1, 0, 6, 32'h106, 0, 32'h0,   0, 1};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        check("reset count",    32'(count),    32'd0);
        check("reset RegWrite", 32'(RegWrite), 32'd0);
        check("reset WN",       32'(WN),       32'd0);
        check("reset WD",       WD,            32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset ready",    32'(ready),    32'd1);
        rst_n = 1'b1;

        for (int v = 0; v < int'(NVEC); v++) begin
            drive(vecs[v].mv, vecs[v].mwn, vecs[v].mwd, vecs[v].av, vecs[v].awn, vecs[v].awd, vecs[v].qrn);
            step();
            check($sformatf("v%0d ready", v),    32'(ready),    32'(vecs[v].e_ready));
            check($sformatf("v%0d RegWrite", v), 32'(RegWrite), 32'(vecs[v].e_rw));
            check($sformatf("v%0d WN", v),       32'(WN),       32'(vecs[v].e_wn));
            check($sformatf("v%0d WD", v),       WD,            vecs[v].e_wd);
            check($sformatf("v%0d q_hit", v),    32'(q_hit),    32'(vecs[v].e_hit));
            check($sformatf("v%0d q_data", v),   q_data,        vecs[v].e_qd);
            check($sformatf("v%0d count", v),    32'(count),    32'(vecs[v].e_count));
            check($sformatf("v%0d overflow", v), 32'(overflow), 32'(vecs[v].e_ovf));
        end

        // steady state: one push per cycle alternating sources, one pop per cycle
        for (int k = 1; k <= 20; k++) begin
            if ((k % 2) == 1) begin
                drive(1, 5'((k % 31) + 1), 32'h1000 + 32'(k - 1), 0, 0, 0, 0);
            end else begin
                drive(0, 0, 0, 1, 5'((k % 31) + 1), 32'h1000 + 32'(k - 1), 0);
            end
            step();
            check($sformatf("steady%0d count", k), 32'(count), 32'd1);
            if (k >= 2) begin
                check($sformatf("steady%0d RegWrite", k), 32'(RegWrite), 32'd1);
                check($sformatf("steady%0d WD", k), WD, 32'h1000 + 32'(k - 2));
                check($sformatf("steady%0d WN", k), 32'(WN), 32'(((k - 1) % 31) + 1));
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        check("steady tail RegWrite", 32'(RegWrite), 32'd1);
        check("steady tail WD",       WD,            32'h1000 + 32'd19);
        step();
        check("steady end RegWrite",  32'(RegWrite), 32'd0);
        check("steady end count",     32'(count),    32'd0);

        // reset with three entries pending and a write in the output register
        drive(1, 9, 32'h901, 1, 10, 32'h902, 0);
        step();
        drive(1, 11, 32'h903, 1, 12, 32'h904, 0);
        step();
        check("prerst count",    32'(count),    32'd3);
        check("prerst RegWrite", 32'(RegWrite), 32'd1);
        check("prerst overflow", 32'(overflow), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 9);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst count",    32'(count),    32'd0);
        check("midrst RegWrite", 32'(RegWrite), 32'd0);
        check("midrst overflow", 32'(overflow), 32'd0);
        check("midrst WN",       32'(WN),       32'd0);
        check("midrst q_hit",    32'(q_hit),    32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("postrst%0d RegWrite", k), 32'(RegWrite), 32'd0);
            check($sformatf("postrst%0d count", k),    32'(count),    32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Writer-side front end for the single-write-port register file.
- Accepts retiring results from two pipeline sources each cycle: the MEM-stage load return and the EX-stage ALU result.
- Holds them in a small in-order FIFO and drains at most one per cycle onto the register file's RegWrite/WN/WD port.
- Provides a combinational lookup of the youngest not-yet-written value for any register number, so decode can forward or stall.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 4
AW, 2, log2(DEPTH)
DW, 32, data width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
mem_valid  input  1  load result present this cycle
mem_wn  input  5  load destination register
mem_wd  input  DW  load data
alu_valid  input  1  ALU result present this cycle
alu_wn  input  5  ALU destination register
alu_wd  input  DW  ALU data
ready  output  1  queue can accept both sources this cycle
RegWrite  output  1  register-file write enable (registered)
WN  output  5  register-file write number (registered)
WD  output  DW  register-file write data (registered)
q_rn  input  5  lookup register number
q_hit  output  1  a pending write to q_rn exists
q_data  output  DW  data of youngest pending write to q_rn
count  output  AW+1  entries currently in FIFO (excludes output register)
overflow  output  1  sticky: an input was dropped

Behaviour:
- Reset:
  - Applies when rst_n=0 at a rising edge.
  - Clears count, rd_ptr, wr_ptr, RegWrite, WN, WD and overflow to 0.
  - Reset mid-operation discards every pending entry, including the output register. No partial write is issued afterwards.
- Enqueue filter: a source is enqueued only when its valid=1 and its wn!=0. Writes to r0 are silently dropped and never affect overflow.
- Ordering: when both sources enqueue in the same cycle, mem is written at wr_ptr and alu at wr_ptr+1, because mem is the older instruction. wr_ptr advances by the number enqueued (0, 1 or 2) and wraps modulo DEPTH.
- ready: equals (count <= DEPTH-2). It is a function of registered count only; there is no combinational path from the valid inputs.
- Overflow: an enqueue attempted while ready=0 is dropped entirely (both sources) and sets overflow=1. overflow stays set until reset.
- Drain, every edge:
  - If count>0: output register loads the head (RegWrite=1, WN, WD from the head), and rd_ptr advances.
  - Else: RegWrite=0; WN and WD hold their previous values.
- Latency: an entry accepted at edge N drives RegWrite in the cycle after edge N+1, at the earliest. The register file commits it at edge N+2.
- Throughput: one write per cycle.
- Simultaneous push and pop: count_next = count + pushes - pop. Full and empty are derived from count, never from pointer equality.
- Lookup (combinational):
  - Search valid FIFO entries plus the output register when RegWrite=1.
  - Youngest match wins; the priority order is the newest FIFO entry first and the output register last.
  - q_rn=0 gives q_hit=0 and q_data=0. No match gives q_hit=0 and q_data=0.
  - Entries arriving in the current cycle are not visible to the lookup.
- Arithmetic: pointers are AW bits and wrap naturally. count is AW+1 bits and never exceeds DEPTH.

Test Plan:
- Reset, then mem_valid=1 (wn=5, wd=0x11) for one cycle -> count=1 after edge 1; RegWrite=1, WN=5, WD=0x11 after edge 2; count=0; RegWrite=0 after edge 3.
- Same cycle mem (wn=3, wd=0xA) and alu (wn=3, wd=0xB) -> RegWrite pulses for two consecutive cycles in order 0xA then 0xB. While both are pending, q_rn=3 gives q_hit=1 with q_data=0xB. After the drain, q_hit=0.
- alu_valid=1 with wn=0, wd=0xFF -> count stays 0, RegWrite never asserts, overflow stays 0.
- Fill with 2 pairs per cycle for 3 cycles with distinct data -> ready falls when count reaches 3. The third pair is dropped and overflow=1. The surviving entries drain in order with no duplicates; pointers wrap correctly past DEPTH.
- Steady state with one push and one pop per cycle for 20 cycles -> count stays constant, RegWrite stays continuously high, and the data sequence matches the input sequence exactly.
- With 3 entries pending and RegWrite=1, assert rst_n=0 for one edge -> count=0, RegWrite=0, overflow=0 on the next cycle, and no stale write appears afterwards.
